// File: rtl/peripheral_mpi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_mpi_pkg
// Brief    : Shared types and constants for the MPI NoC ingress path.
// Revision : 1.0 - initial release
// ============================================================================
package peripheral_mpi_pkg;

    localparam int c_NOC_FLIT_WIDTH = 32;

    typedef enum logic [0:0] {
        BUF_BUFFER = 1'b0,
        BUF_DRAIN  = 1'b1
    } mpi_buf_state_t;

    typedef struct packed {
        logic                        last;
        logic [c_NOC_FLIT_WIDTH-1:0] flit;
    } mpi_flit_t;

endpackage
`default_nettype wire

// File: rtl/peripheral_mpi_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_mpi_buffer_ram
// Brief    : Flit storage, one synchronous write port, one asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_mpi_buffer_ram #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are intentionally left unreset; validity is tracked by pointers.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/peripheral_mpi_packet_buffer.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_mpi_packet_buffer
// Brief    : Store-and-forward flit buffer with cut-through drain for packets
//            larger than the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_mpi_packet_buffer
    import peripheral_mpi_pkg::*;
#(
    parameter int NOC_FLIT_WIDTH = c_NOC_FLIT_WIDTH,
    parameter int SIZE           = 16,
    parameter int FULLPACKET     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NOC_FLIT_WIDTH-1:0]   in_flit,
    input  logic                        in_last,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [NOC_FLIT_WIDTH-1:0]   out_flit,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(SIZE+1)-1:0]   count
);

    localparam int c_AW = $clog2(SIZE);
    localparam int c_PW = c_AW + 1;
    localparam int c_CW = $clog2(SIZE + 1);
    localparam int c_EW = NOC_FLIT_WIDTH + 1;

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_pkt_cnt;
    mpi_buf_state_t  r_state;
    mpi_buf_state_t  w_state_nxt;

    logic            w_empty;
    logic            w_full;
    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_out_valid;
    logic            w_head_last;
    logic [c_EW-1:0] w_head;
    logic [c_PW-1:0] w_fill;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                     (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);

    assign w_wr_en     = in_valid && !w_full;
    assign w_rd_en     = w_out_valid && out_ready;
    assign w_head_last = w_head[NOC_FLIT_WIDTH];

    peripheral_mpi_buffer_ram #(
        .WIDTH (c_EW),
        .DEPTH (SIZE)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[c_AW-1:0]),
        .i_wr_data ({in_last, in_flit}),
        .i_rd_addr (r_rd_ptr[c_AW-1:0]),
        .o_rd_data (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    // Number of complete packets held; a simultaneous push and pop of last
    // flits cancels out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else begin
            case ({w_wr_en && in_last, w_rd_en && w_head_last})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + c_CW'(1);
                2'b01:   r_pkt_cnt <= r_pkt_cnt - c_CW'(1);
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_BUFFER;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The DRAIN exit uses the raw read condition rather than w_rd_en so that
    // out_valid never feeds back into the block that produces it.
    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        if (FULLPACKET == 0) begin
            w_out_valid = !w_empty;
        end else begin
            case (r_state)
                BUF_BUFFER: begin
                    w_out_valid = (r_pkt_cnt != '0);
                    if (w_full && (r_pkt_cnt == '0)) begin
                        w_state_nxt = BUF_DRAIN;
                    end
                end
                BUF_DRAIN: begin
                    w_out_valid = !w_empty;
                    if (!w_empty && out_ready && w_head_last) begin
                        w_state_nxt = BUF_BUFFER;
                    end
                end
                default: begin
                    w_state_nxt = BUF_BUFFER;
                end
            endcase
        end
    end

    assign w_fill = r_wr_ptr - r_rd_ptr;

    assign in_ready  = !w_full;
    assign out_valid = w_out_valid;
    assign out_flit  = {NOC_FLIT_WIDTH{w_out_valid}} & w_head[NOC_FLIT_WIDTH-1:0];
    assign out_last  = w_out_valid & w_head_last;
    assign count     = c_CW'(w_fill);

endmodule
`default_nettype wire

// File: tb/tb_peripheral_mpi_packet_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_mpi_packet_buffer
// Brief    : Self-checking bench: vector table, directed corner cases and a
//            queue-based reference model under random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_mpi_packet_buffer;

    localparam int c_W          = 32;
    localparam int c_SIZE       = 16;
    localparam int c_FULLPACKET = 1;
    localparam int c_CW         = $clog2(c_SIZE + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [c_W-1:0]  in_flit;
    logic            in_last;
    logic            in_valid;
    logic            in_ready;
    logic [c_W-1:0]  out_flit;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic [c_CW-1:0] count;

    always #5 clk = ~clk;

    peripheral_mpi_packet_buffer #(
        .NOC_FLIT_WIDTH (c_W),
        .SIZE           (c_SIZE),
        .FULLPACKET     (c_FULLPACKET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a queue of {last, flit} plus the drain-mode flag.
    logic [c_W:0] m_q[$];
    bit           m_drain;
    int           m_lasts;
    bit           model_check;

    logic            e_ir, e_ov, e_l;
    logic [c_W-1:0]  e_f;
    logic [c_CW-1:0] e_cnt;
    logic            a_ir, a_ov, a_l;
    logic [c_W-1:0]  a_f;
    logic [c_CW-1:0] a_cnt;

    typedef struct {
        logic [c_W-1:0]  flit;
        logic            last;
        logic            valid;
        logic            ready;
        logic            ir;
        logic            ov;
        logic [c_W-1:0]  oflit;
        logic            olast;
        logic [c_CW-1:0] cnt;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_eval();
        m_lasts = 0;
        foreach (m_q[i]) begin
            if (m_q[i][c_W]) m_lasts++;
        end
        e_ir = (m_q.size() < c_SIZE);
        if (c_FULLPACKET != 0) begin
            e_ov = m_drain ? (m_q.size() != 0) : (m_lasts != 0);
        end else begin
            e_ov = (m_q.size() != 0);
        end
        e_f   = e_ov ? m_q[0][c_W-1:0] : '0;
        e_l   = e_ov ? m_q[0][c_W] : 1'b0;
        e_cnt = c_CW'(m_q.size());
    endfunction

    function automatic void model_update(input logic v, input logic r, input logic [c_W:0] ent);
        bit wr;
        bit rd;
        wr = v && e_ir;
        rd = e_ov && r;
        if (!m_drain) begin
            if (m_q.size() == c_SIZE && m_lasts == 0) m_drain = 1'b1;
        end else if (rd && m_q[0][c_W]) begin
            m_drain = 1'b0;
        end
        if (rd) void'(m_q.pop_front());
        if (wr) m_q.push_back(ent);
    endfunction

    task automatic step(input logic [c_W-1:0] f, input logic l, input logic v, input logic r);
        @(negedge clk);
        in_flit   = f;
        in_last   = l;
        in_valid  = v;
        out_ready = r;
        #1;
        model_eval();
        a_ir  = in_ready;
        a_ov  = out_valid;
        a_f   = out_flit;
        a_l   = out_last;
        a_cnt = count;
        if (model_check) begin
            check("mdl_in_ready",  a_ir,  e_ir);
            check("mdl_out_valid", a_ov,  e_ov);
            check("mdl_out_flit",  a_f,   e_f);
            check("mdl_out_last",  a_l,   e_l);
            check("mdl_count",     a_cnt, e_cnt);
        end
        @(posedge clk);
        model_update(v, r, {l, f});
    endtask

    initial begin
        int sent;
        int got;
        int cyc;
        logic rr;
        logic vv;

        rst = 1'b1;
        in_flit = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        m_drain = 1'b0;
        model_check = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset, then a 3-flit packet with out_ready held high.
        vt[0] = '{32'h0,  0, 0, 1, 1, 0, 32'h0,  0, 0};
        vt[1] = '{32'hA0, 0, 1, 1, 1, 0, 32'h0,  0, 0};
        vt[2] = '{32'hA1, 0, 1, 1, 1, 0, 32'h0,  0, 1};
        vt[3] = '{32'hA2, 1, 1, 1, 1, 0, 32'h0,  0, 2};
        vt[4] = '{32'h0,  0, 0, 1, 1, 1, 32'hA0, 0, 3};
        vt[5] = '{32'h0,  0, 0, 1, 1, 1, 32'hA1, 0, 2};
        vt[6] = '{32'h0,  0, 0, 1, 1, 1, 32'hA2, 1, 1};
        vt[7] = '{32'h0,  0, 0, 1, 1, 0, 32'h0,  0, 0};
        for (int i = 0; i < 8; i++) begin
            step(vt[i].flit, vt[i].last, vt[i].valid, vt[i].ready);
            check($sformatf("tbl%0d_in_ready", i),  a_ir,  vt[i].ir);
            check($sformatf("tbl%0d_out_valid", i), a_ov,  vt[i].ov);
            check($sformatf("tbl%0d_out_flit", i),  a_f,   vt[i].oflit);
            check($sformatf("tbl%0d_out_last", i),  a_l,   vt[i].olast);
            check($sformatf("tbl%0d_count", i),     a_cnt, vt[i].cnt);
        end

        // Oversized packet: fill with non-last flits, expect cut-through drain.
        for (int i = 0; i < c_SIZE; i++) step(32'h100 + i, 1'b0, 1'b1, 1'b0);
        step('0, 0, 0, 0);
        check("full_in_ready", a_ir, 0);
        check("full_count", a_cnt, c_SIZE);
        check("full_out_valid_same_cycle", a_ov, 0);
        step('0, 0, 0, 0);
        check("drain_out_valid", a_ov, 1);
        check("drain_head", a_f, 32'h100);
        for (int i = 0; i < c_SIZE; i++) begin
            step('0, 0, 0, 1);
            check("drain_flit", a_f, 32'h100 + i);
            check("drain_last", a_l, 0);
        end
        step('0, 0, 0, 0);
        check("drain_empty_valid", a_ov, 0);
        step(32'h200, 0, 1, 0);
        step('0, 0, 0, 0);
        check("drain_persists", a_ov, 1);
        step('0, 0, 0, 1);
        step(32'h201, 1, 1, 0);
        step('0, 0, 0, 1);
        check("drain_tail_last", a_l, 1);
        step(32'h202, 0, 1, 0);
        step('0, 0, 0, 0);
        check("back_to_buffer_valid", a_ov, 0);
        check("back_to_buffer_count", a_cnt, 1);
        step(32'h203, 1, 1, 0);
        step('0, 0, 0, 1);
        step('0, 0, 0, 1);
        step('0, 0, 0, 0);

        // Concurrent pop of a last flit and push of another.
        step(32'h300, 1, 1, 0);
        step(32'h301, 1, 1, 1);
        check("simul_read", a_f, 32'h300);
        step('0, 0, 0, 0);
        check("simul_out_valid", a_ov, 1);
        check("simul_head", a_f, 32'h301);
        check("simul_count", a_cnt, 1);

        // Backpressure: head must hold steady.
        for (int i = 0; i < 5; i++) begin
            step(32'h3FF, 0, 0, 0);
            check("bp_flit", a_f, 32'h301);
            check("bp_count", a_cnt, 1);
        end
        step('0, 0, 0, 1);

        // 40 single-flit packets through random backpressure.
        sent = 0; got = 0; cyc = 0;
        while (got < 40 && cyc < 2000) begin
            rr = 1'(($urandom() & 1));
            vv = (sent < 40);
            step(32'(sent), 1'b1, vv, rr);
            if (vv && a_ir) sent++;
            if (a_ov && rr) begin
                check("wrap_order", a_f, 32'(got));
                got++;
            end
            cyc++;
        end
        check("wrap_received", got, 40);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            step($urandom(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
                 (i < 300) ? ($urandom_range(0, 3) == 0) : 1'(($urandom() & 1)));
        end

        // Asynchronous reset mid-packet.
        step(32'h500, 0, 1, 0);
        step(32'h501, 1, 1, 0);
        step(32'h502, 0, 1, 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flit", out_flit, 0);
        check("rst_out_last", out_last, 0);
        check("rst_count", count, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_drain = 1'b0;
        step(32'h600, 1, 1, 0);
        step('0, 0, 0, 1);
        check("post_rst_flit", a_f, 32'h600);
        step('0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
